alu_exec_stage: RTL and testbench

- Execute stage directly upstream of the rd-select mux.
- Accepts one instruction per handshake: a 2-bit opcode and two 16-bit source operands.
- Computes the result in the matching functional unit:
  - add and sub: single cycle.
  - mul: iterative shift-add.
  - div: iterative restoring divider.
- Presents registered add_rd/sub_rd/mul_rd/div_rd together with out_opcode, so the downstream mux selects the correct rd value.

---
 rtl/alu_exec_stage.sv | 144 ++++++++++++++
 tb/tb_alu_exec_stage.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_stage.sv
// Execute stage: single-cycle add/sub, iterative shift-add multiply and
// restoring divide, with per-opcode registered results for the rd-select mux.
module alu_exec_stage #(
  parameter int WIDTH = 16,
  parameter int ITER  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_opcode,
  input  logic [WIDTH-1:0] rs1_val,
  input  logic [WIDTH-1:0] rs2_val,
  output logic [WIDTH-1:0] add_rd,
  output logic [WIDTH-1:0] sub_rd,
  output logic [WIDTH-1:0] mul_rd,
  output logic [WIDTH-1:0] div_rd,
  output logic [1:0]       out_opcode,
  output logic             out_valid,
  output logic             div_by_zero
);
  localparam int CW = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  typedef enum logic [1:0] {IDLE, MUL_BUSY, DIV_BUSY} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  // a_q: multiplicand (shifts left) or divisor
  // b_q: multiplier (shifts right) or dividend/quotient shift register
  // acc_q: product accumulator or partial remainder
  logic [WIDTH-1:0] a_q, b_q, acc_q;
  logic [WIDTH-1:0] add_rd_q, sub_rd_q, mul_rd_q, div_rd_q;
  logic [1:0]       out_opcode_q;
  logic             out_valid_q, div_by_zero_q;

  logic [WIDTH-1:0] mul_acc_d;
  logic [WIDTH:0]   div_r, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem_d, div_quo_d;

  // One iteration of each datapath, evaluated from the current working registers
  always_comb begin
    mul_acc_d = acc_q + (b_q[0] ? a_q : '0);
    div_r     = {acc_q, b_q[WIDTH-1]};
    div_diff  = div_r - {1'b0, a_q};
    div_ge    = (div_r >= {1'b0, a_q});
    div_rem_d = div_ge ? div_diff[WIDTH-1:0] : div_r[WIDTH-1:0];
    div_quo_d = {b_q[WIDTH-2:0], div_ge};
  end

  // Control FSM, iteration counter, working registers and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      a_q           <= '0;
      b_q           <= '0;
      acc_q         <= '0;
      add_rd_q      <= '0;
      sub_rd_q      <= '0;
      mul_rd_q      <= '0;
      div_rd_q      <= '0;
      out_opcode_q  <= 2'b00;
      out_valid_q   <= 1'b0;
      div_by_zero_q <= 1'b0;
    end else begin
      out_valid_q   <= 1'b0;
      div_by_zero_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            cnt_q <= '0;
            case (in_opcode)
              2'b00: begin
                add_rd_q     <= rs1_val + rs2_val;
                out_opcode_q <= 2'b00;
                out_valid_q  <= 1'b1;
              end
              2'b01: begin
                sub_rd_q     <= rs1_val - rs2_val;
                out_opcode_q <= 2'b01;
                out_valid_q  <= 1'b1;
              end
              2'b10: begin
                a_q     <= rs1_val;
                b_q     <= rs2_val;
                acc_q   <= '0;
                state_q <= MUL_BUSY;
              end
              default: begin
                if (rs2_val == '0) begin
                  // Divide by zero never enters the iterative unit
                  div_rd_q      <= '1;
                  div_by_zero_q <= 1'b1;
                  out_opcode_q  <= 2'b11;
                  out_valid_q   <= 1'b1;
                end else begin
                  a_q     <= rs2_val;
                  b_q     <= rs1_val;
                  acc_q   <= '0;
                  state_q <= DIV_BUSY;
                end
              end
            endcase
          end
        end
        MUL_BUSY: begin
          acc_q <= mul_acc_d;
          a_q   <= a_q << 1;
          b_q   <= b_q >> 1;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            mul_rd_q     <= mul_acc_d;
            out_opcode_q <= 2'b10;
            out_valid_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end
        DIV_BUSY: begin
          acc_q <= div_rem_d;
          b_q   <= div_quo_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            div_rd_q     <= div_quo_d;
            out_opcode_q <= 2'b11;
            out_valid_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign add_rd      = add_rd_q;
  assign sub_rd      = sub_rd_q;
  assign mul_rd      = mul_rd_q;
  assign div_rd      = div_rd_q;
  assign out_opcode  = out_opcode_q;
  assign out_valid   = out_valid_q;
  assign div_by_zero = div_by_zero_q;
endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage against an arithmetic reference model.
module tb_alu_exec_stage;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, div_by_zero;
  logic [1:0]  in_opcode, out_opcode;
  logic [15:0] rs1_val, rs2_val, add_rd, sub_rd, mul_rd, div_rd;

  int pass_cnt = 0;
  int total    = 0;
  // Expected contents of the four held result registers
  logic [15:0] m_add = 16'h0, m_sub = 16'h0, m_mul = 16'h0, m_div = 16'h0;

  alu_exec_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .add_rd(add_rd), .sub_rd(sub_rd), .mul_rd(mul_rd), .div_rd(div_rd),
    .out_opcode(out_opcode), .out_valid(out_valid), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_res(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    int unsigned ua = a, ub = b;
    case (op)
      2'd0:    return 16'((ua + ub) % 65536);
      2'd1:    return 16'((ua + 65536 - ub) % 65536);
      2'd2:    return 16'((ua * ub) % 65536);
      default: return (ub == 0) ? 16'hFFFF : 16'(ua / ub);
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [15:0] b);
    return (op == 2'd2 || (op == 2'd3 && b != 16'd0)) ? 17 : 1;
  endfunction

  task automatic model_update(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      2'd0:    m_add = ref_res(op, a, b);
      2'd1:    m_sub = ref_res(op, a, b);
      2'd2:    m_mul = ref_res(op, a, b);
      default: m_div = ref_res(op, a, b);
    endcase
  endtask

  function automatic logic [15:0] sel_rd(input logic [1:0] op);
    case (op)
      2'd0:    return add_rd;
      2'd1:    return sub_rd;
      2'd2:    return mul_rd;
      default: return div_rd;
    endcase
  endfunction

  // Issue one instruction from IDLE; returns cycles to out_valid and cycles with in_ready low
  task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                        output int lat, output int busy);
    in_valid = 1'b1; in_opcode = op; rs1_val = a; rs2_val = b;
    busy = 0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      if (!in_ready) busy++;
      @(posedge clk); #1;
      lat++;
    end
    model_update(op, a, b);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_opcode = 2'd0; rs1_val = 16'h0; rs2_val = 16'h0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", in_ready); else pass_cnt++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", out_valid); else pass_cnt++;
    total++; if ({add_rd, sub_rd, mul_rd, div_rd} !== 64'h0) $display("FAIL reset_rd got %h exp 0", {add_rd, sub_rd, mul_rd, div_rd}); else pass_cnt++;
    total++; if ({out_opcode, div_by_zero} !== 3'b0) $display("FAIL reset_op_dz got %b exp 000", {out_opcode, div_by_zero}); else pass_cnt++;
  endtask

  task automatic test_add();
    int lat, busy;
    run_op(2'd0, 16'h0005, 16'h0003, lat, busy);
    total++; if (lat !== 1) $display("FAIL add_lat got %0d exp 1", lat); else pass_cnt++;
    total++; if (add_rd !== 16'h0008) $display("FAIL add_rd got %h exp 0008", add_rd); else pass_cnt++;
    total++; if (out_opcode !== 2'b00) $display("FAIL add_op got %b exp 00", out_opcode); else pass_cnt++;
    total++; if ({sub_rd, mul_rd, div_rd} !== 48'h0) $display("FAIL add_others got %h exp 0", {sub_rd, mul_rd, div_rd}); else pass_cnt++;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) $display("FAIL add_pulse got %b exp 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; in_opcode = 2'd1; rs1_val = 16'h0000; rs2_val = 16'h0001;
    @(posedge clk); #1;
    total++; if ({out_valid, out_opcode, sub_rd} !== {1'b1, 2'b01, 16'hFFFF}) $display("FAIL b2b_sub got %b %b %h exp 1 01 ffff", out_valid, out_opcode, sub_rd); else pass_cnt++;
    in_opcode = 2'd0; rs1_val = 16'hFFFF; rs2_val = 16'h0002;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if ({out_valid, out_opcode, add_rd} !== {1'b1, 2'b00, 16'h0001}) $display("FAIL b2b_add got %b %b %h exp 1 00 0001", out_valid, out_opcode, add_rd); else pass_cnt++;
    m_sub = 16'hFFFF; m_add = 16'h0001;
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    int lat, busy;
    run_op(2'd2, 16'h0123, 16'h0010, lat, busy);
    total++; if (busy !== 16) $display("FAIL mul_busy got %0d exp 16", busy); else pass_cnt++;
    total++; if (lat !== 17) $display("FAIL mul_lat got %0d exp 17", lat); else pass_cnt++;
    total++; if ({mul_rd, out_opcode, in_ready} !== {16'h1230, 2'b10, 1'b1}) $display("FAIL mul_res got %h %b %b exp 1230 10 1", mul_rd, out_opcode, in_ready); else pass_cnt++;
    total++; if (add_rd !== m_add) $display("FAIL mul_add_hold got %h exp %h", add_rd, m_add); else pass_cnt++;
    run_op(2'd2, 16'h0100, 16'h0100, lat, busy);
    total++; if (mul_rd !== 16'h0000 || lat !== 17) $display("FAIL mul_ovf got %h lat %0d exp 0000 lat 17", mul_rd, lat); else pass_cnt++;
  endtask

  task automatic test_div();
    int lat, busy;
    run_op(2'd3, 16'd1000, 16'd7, lat, busy);
    total++; if (lat !== 17 || busy !== 16) $display("FAIL div_timing got lat %0d busy %0d exp 17 16", lat, busy); else pass_cnt++;
    total++; if ({div_rd, div_by_zero, out_opcode} !== {16'd142, 1'b0, 2'b11}) $display("FAIL div_res got %0d %b %b exp 142 0 11", div_rd, div_by_zero, out_opcode); else pass_cnt++;
    run_op(2'd3, 16'd5, 16'd0, lat, busy);
    total++; if (lat !== 1) $display("FAIL dz_lat got %0d exp 1", lat); else pass_cnt++;
    total++; if ({div_rd, div_by_zero} !== {16'hFFFF, 1'b1}) $display("FAIL dz_res got %h %b exp ffff 1", div_rd, div_by_zero); else pass_cnt++;
    @(posedge clk); #1;
    total++; if ({out_valid, div_by_zero} !== 2'b00) $display("FAIL dz_pulse got %b exp 00", {out_valid, div_by_zero}); else pass_cnt++;
  endtask

  task automatic test_reset_mid_div();
    int lat, busy;
    bit seen = 1'b0;
    in_valid = 1'b1; in_opcode = 2'd3; rs1_val = 16'd1000; rs2_val = 16'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_add = 16'h0; m_sub = 16'h0; m_mul = 16'h0; m_div = 16'h0;
    total++; if (seen !== 1'b0 || out_valid !== 1'b0) $display("FAIL rstdiv_valid got %b %b exp 0 0", seen, out_valid); else pass_cnt++;
    total++; if ({add_rd, sub_rd, mul_rd, div_rd, out_opcode, div_by_zero} !== 67'h0) $display("FAIL rstdiv_outs got %h exp 0", {add_rd, sub_rd, mul_rd, div_rd, out_opcode, div_by_zero}); else pass_cnt++;
    total++; if (in_ready !== 1'b1) $display("FAIL rstdiv_ready got %b exp 1", in_ready); else pass_cnt++;
    repeat (20) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    total++; if (seen !== 1'b0) $display("FAIL rstdiv_late_valid got %b exp 0", seen); else pass_cnt++;
    run_op(2'd0, 16'd2, 16'd3, lat, busy);
    total++; if (add_rd !== 16'd5 || lat !== 1) $display("FAIL rstdiv_add got %h lat %0d exp 0005 lat 1", add_rd, lat); else pass_cnt++;
  endtask

  task automatic test_held_valid();
    int n = 0;
    int lat;
    in_valid = 1'b1; in_opcode = 2'd3; rs1_val = 16'd100; rs2_val = 16'd9;
    @(posedge clk); #1;
    in_opcode = 2'd2; rs1_val = 16'd7; rs2_val = 16'd9;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    total++; if (n !== 16) $display("FAIL held_busy got %0d exp 16", n); else pass_cnt++;
    total++; if ({out_valid, out_opcode, div_rd} !== {1'b1, 2'b11, 16'd11}) $display("FAIL held_div got %b %b %0d exp 1 11 11", out_valid, out_opcode, div_rd); else pass_cnt++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if (in_ready !== 1'b0) $display("FAIL held_accept got ready %b exp 0", in_ready); else pass_cnt++;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    total++; if (lat !== 17) $display("FAIL held_mul_lat got %0d exp 17", lat); else pass_cnt++;
    total++; if ({mul_rd, div_rd} !== {16'd63, 16'd11}) $display("FAIL held_mul_res got %0d %0d exp 63 11", mul_rd, div_rd); else pass_cnt++;
    m_div = 16'd11; m_mul = 16'd63;
  endtask

  task automatic test_random();
    int lat, busy;
    logic [1:0]  op;
    logic [15:0] a, b;
    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = 16'($urandom);
      b  = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom);
      if ($urandom_range(0, 3) == 0) b = 16'($urandom_range(1, 15));
      run_op(op, a, b, lat, busy);
      total++; if (lat !== ref_lat(op, b)) $display("FAIL rnd_lat op %0d a %h b %h got %0d exp %0d", op, a, b, lat, ref_lat(op, b)); else pass_cnt++;
      total++; if (sel_rd(op) !== ref_res(op, a, b)) $display("FAIL rnd_res op %0d a %h b %h got %h exp %h", op, a, b, sel_rd(op), ref_res(op, a, b)); else pass_cnt++;
      total++; if ({add_rd, sub_rd, mul_rd, div_rd} !== {m_add, m_sub, m_mul, m_div}) $display("FAIL rnd_hold got %h exp %h", {add_rd, sub_rd, mul_rd, div_rd}, {m_add, m_sub, m_mul, m_div}); else pass_cnt++;
      total++; if ({out_opcode, div_by_zero} !== {op, (op == 2'd3 && b == 16'd0)}) $display("FAIL rnd_op_dz got %b exp %b", {out_opcode, div_by_zero}, {op, (op == 2'd3 && b == 16'd0)}); else pass_cnt++;
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b0) $display("FAIL rnd_pulse got %b exp 0", out_valid); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_mul();
    test_div();
    test_reset_mid_div();
    test_held_valid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
